// File: rtl/turn_signal_ctrl.sv
// Turn-signal controller: synchronised switches drive an IDLE/LEFT/RIGHT/HAZARD
// state machine with tap-to-blink and a step prescaler for the tail-light FSM.
module turn_signal_ctrl #(
    parameter int DIV       = 4,
    parameter int TAP_MAX   = 8,
    parameter int TAP_STEPS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    output logic       left,
    output logic       right,
    output logic       step,
    output logic [1:0] mode
);

    localparam int PW = $clog2(DIV);
    localparam int HW = $clog2(TAP_MAX + 1);
    localparam int SW = $clog2(TAP_STEPS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(TAP_MAX);
    localparam logic [SW-1:0] STEP_LAST = SW'(TAP_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LEFT   = 2'b01,
        S_RIGHT  = 2'b10,
        S_HAZARD = 2'b11
    } state_t;

    logic          r_ls, r_rs, r_hs;
    state_t        r_state;
    logic          r_tap;
    logic [HW-1:0] r_hold;
    logic [SW-1:0] r_steps;
    logic [PW-1:0] r_pre;
    logic          r_left, r_right;
    logic [1:0]    r_mode;

    state_t        w_next;
    state_t        w_opp_state;
    logic          w_tap_next;
    logic [HW-1:0] w_hold_next;
    logic [SW-1:0] w_steps_next;
    logic [PW-1:0] w_pre_next;
    logic          w_step;
    logic          w_own;
    logic          w_opp;

    // Side-relative views so LEFT and RIGHT share one set of rules
    always_comb begin
        w_step      = (r_state != S_IDLE) && (r_pre == PRE_LAST);
        w_own       = (r_state == S_LEFT) ? r_ls : r_rs;
        w_opp       = (r_state == S_LEFT) ? r_rs : r_ls;
        w_opp_state = (r_state == S_LEFT) ? S_RIGHT : S_LEFT;
    end

    // Next-state, tap, hold, step-count and prescaler logic
    always_comb begin
        w_next       = r_state;
        w_tap_next   = r_tap;
        w_hold_next  = r_hold;
        w_steps_next = r_steps;
        w_pre_next   = '0;
        if (r_hs || (r_ls && r_rs)) begin
            w_next = S_HAZARD;
        end else begin
            unique case (r_state)
                S_IDLE, S_HAZARD: begin
                    if (r_ls)      w_next = S_LEFT;
                    else if (r_rs) w_next = S_RIGHT;
                    else           w_next = S_IDLE;
                end
                S_LEFT, S_RIGHT: begin
                    if (w_opp) begin
                        w_next = w_opp_state;
                    end else if (w_own) begin
                        if (r_tap) begin
                            w_tap_next  = 1'b0;
                            w_hold_next = '0;
                        end else if (r_hold != HOLD_MAX) begin
                            w_hold_next = r_hold + 1'b1;
                        end
                    end else if (!r_tap) begin
                        if (r_hold < HOLD_MAX) begin
                            w_tap_next   = 1'b1;
                            w_steps_next = '0;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else if (w_step) begin
                        if (r_steps == STEP_LAST) w_next = S_IDLE;
                        else w_steps_next = r_steps + 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
        if (w_next != r_state) begin
            w_tap_next   = 1'b0;
            w_hold_next  = '0;
            w_steps_next = '0;
        end
        if ((w_next == r_state) && (r_state != S_IDLE)) begin
            w_pre_next = (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        end
    end

    // Switch sync stage, state registers and registered output decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ls    <= 1'b0;
            r_rs    <= 1'b0;
            r_hs    <= 1'b0;
            r_state <= S_IDLE;
            r_tap   <= 1'b0;
            r_hold  <= '0;
            r_steps <= '0;
            r_pre   <= '0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_mode  <= 2'b00;
        end else begin
            r_ls    <= left_sw;
            r_rs    <= right_sw;
            r_hs    <= hazard_sw;
            r_state <= w_next;
            r_tap   <= w_tap_next;
            r_hold  <= w_hold_next;
            r_steps <= w_steps_next;
            r_pre   <= w_pre_next;
            r_left  <= (w_next == S_LEFT) || (w_next == S_HAZARD);
            r_right <= (w_next == S_RIGHT) || (w_next == S_HAZARD);
            r_mode  <= w_next;
        end
    end

    assign left  = r_left;
    assign right = r_right;
    assign mode  = r_mode;
    assign step  = w_step;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl at DIV=4, TAP_MAX=8, TAP_STEPS=6.
// Each tick lands 1 time unit after a rising edge; outputs are sampled there.
module tb_turn_signal_ctrl;

    logic       clk;
    logic       reset;
    logic       left_sw;
    logic       right_sw;
    logic       hazard_sw;
    logic       left;
    logic       right;
    logic       step;
    logic [1:0] mode;

    int n_vec;
    int n_bad;
    int steps_seen;
    int overlap;

    turn_signal_ctrl #(
        .DIV(4),
        .TAP_MAX(8),
        .TAP_STEPS(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .left_sw(left_sw),
        .right_sw(right_sw),
        .hazard_sw(hazard_sw),
        .left(left),
        .right(right),
        .step(step),
        .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (step === 1'b1) steps_seen++;
            if (left === 1'b1 && right === 1'b1) overlap++;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        left_sw   = 1'b0;
        right_sw  = 1'b0;
        hazard_sw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic tap_run(input bit rgt);
        if (rgt) right_sw = 1'b1;
        else     left_sw  = 1'b1;
        tick();
        tick();
        tick();
        left_sw  = 1'b0;
        right_sw = 1'b0;
        steps_seen = 0;
        run(22);
        check(rgt ? "tapR_steps" : "tapL_steps", steps_seen, 6);
        check(rgt ? "tapR_side" : "tapL_side", rgt ? right : left, 1);
        check(rgt ? "tapR_last" : "tapL_last", step, 1);
        tick();
        check(rgt ? "tapR_idle" : "tapL_idle", mode, 0);
        check(rgt ? "tapR_off" : "tapL_off", rgt ? right : left, 0);
        steps_seen = 0;
        run(8);
        check(rgt ? "tapR_quiet" : "tapL_quiet", steps_seen, 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        steps_seen = 0;
        overlap = 0;
        reset = 1'b1;
        left_sw = 1'b0;
        right_sw = 1'b0;
        hazard_sw = 1'b0;

        do_reset();
        check("rst_mode", mode, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_step", step, 0);

        left_sw = 1'b1;
        tick();
        check("hold_lat1", left, 0);
        tick();
        check("hold_left", left, 1);
        check("hold_mode", mode, 1);
        steps_seen = 0;
        run(3);
        check("hold_step_e5", step, 1);
        check("hold_first", steps_seen, 1);
        run(15);
        check("hold_steps", steps_seen, 4);
        left_sw = 1'b0;
        tick();
        check("rel_step", step, 1);
        check("rel_left1", left, 1);
        tick();
        check("rel_left2", left, 0);
        check("rel_mode2", mode, 0);
        check("rel_step2", step, 0);

        tap_run(1'b0);
        tap_run(1'b1);

        do_reset();
        left_sw = 1'b1;
        tick();
        tick();
        tick();
        left_sw = 1'b0;
        tick();
        tick();
        tick();
        tick();
        hazard_sw = 1'b1;
        tick();
        check("haz_lat1", mode, 1);
        tick();
        check("haz_mode", mode, 3);
        check("haz_left", left, 1);
        check("haz_right", right, 1);
        steps_seen = 0;
        run(8);
        check("haz_steps", steps_seen, 2);
        hazard_sw = 1'b0;
        tick();
        check("haz_rel1", mode, 3);
        tick();
        check("haz_rel_mode", mode, 0);
        check("haz_rel_left", left, 0);
        check("haz_rel_right", right, 0);
        steps_seen = 0;
        run(30);
        check("haz_no_tap", steps_seen, 0);
        check("haz_idle", mode, 0);

        do_reset();
        left_sw = 1'b1;
        right_sw = 1'b1;
        tick();
        tick();
        check("both_haz", mode, 3);
        tick();
        right_sw = 1'b0;
        tick();
        check("both_still", mode, 3);
        tick();
        check("both_left", mode, 1);
        check("both_pre0", step, 0);
        steps_seen = 0;
        run(2);
        check("both_quiet", steps_seen, 0);
        tick();
        check("both_step", step, 1);

        do_reset();
        left_sw = 1'b1;
        tick();
        tick();
        tick();
        left_sw = 1'b0;
        right_sw = 1'b1;
        overlap = 0;
        steps_seen = 0;
        run(1);
        check("sw_left", mode, 1);
        run(1);
        check("sw_right", mode, 2);
        check("sw_rside", right, 1);
        check("sw_lside", left, 0);
        check("sw_pre0", step, 0);
        run(3);
        check("sw_step", step, 1);
        check("sw_steps", steps_seen, 1);
        check("sw_overlap", overlap, 0);

        do_reset();
        left_sw = 1'b1;
        tick();
        tick();
        tick();
        left_sw = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("rtap_on", mode, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rtap_left", left, 0);
        check("rtap_right", right, 0);
        check("rtap_step", step, 0);
        check("rtap_mode", mode, 0);
        steps_seen = 0;
        run(12);
        check("rtap_quiet", steps_seen, 0);
        check("rtap_idle", mode, 0);
        left_sw = 1'b1;
        tick();
        tick();
        check("rtap_again", mode, 1);

        do_reset();
        left_sw = 1'b1;
        repeat (8) tick();
        left_sw = 1'b0;
        tick();
        tick();
        check("bnd_tap8", mode, 1);

        do_reset();
        left_sw = 1'b1;
        repeat (9) tick();
        left_sw = 1'b0;
        tick();
        check("bnd_hold9a", mode, 1);
        tick();
        check("bnd_hold9b", mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
